// File: rtl/signed_sub_pipe_if.sv
// Operand/result bundle for signed_sub_pipe.
// The master produces operands and the pipeline enable; the slave returns registered results.
interface signed_sub_pipe_if #(
   parameter int IN_W  = 4,
   parameter int OUT_W = IN_W + 1
);
   logic             ce;
   logic             inValid;
   logic             isSigned;
   logic [IN_W-1:0]  aIn;
   logic [IN_W-1:0]  bIn;
   logic [OUT_W-1:0] subOut;
   logic             outValid;
   logic             ovf;

   modport master (
      output ce, inValid, isSigned, aIn, bIn,
      input  subOut, outValid, ovf
   );

   modport slave (
      input  ce, inValid, isSigned, aIn, bIn,
      output subOut, outValid, ovf
   );
endinterface

// File: rtl/signed_sub_pipe.sv
// Pipelined signed/unsigned subtractor with wrap or saturate narrowing.
// Extension, subtraction and narrowing happen in the first stage; later stages only delay.
module signed_sub_pipe #(
   parameter int IN_W  = 4,
   parameter int OUT_W = IN_W + 1,
   parameter int LAT   = 4,
   parameter int SAT   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   signed_sub_pipe_if.slave bus
);
   localparam int DW = IN_W + 1;

   logic [DW-1:0]        a_ext;
   logic [DW-1:0]        b_ext;
   logic signed [DW-1:0] diff;
   logic [OUT_W-1:0]     nar_res;
   logic                 nar_ovf;

   // One extra bit makes the difference exact for both signed and unsigned operands.
   always_comb begin
      a_ext = {bus.isSigned & bus.aIn[IN_W-1], bus.aIn};
      b_ext = {bus.isSigned & bus.bIn[IN_W-1], bus.bIn};
      diff  = a_ext - b_ext;
   end

   generate
      if (OUT_W >= DW) begin : g_wide
         assign nar_res = OUT_W'(diff);
         assign nar_ovf = 1'b0;
      end else begin : g_narrow
         logic fits;
         // Representable iff every bit dropped by narrowing equals the new sign bit.
         always_comb begin
            fits    = (&diff[IN_W:OUT_W-1]) | ~(|diff[IN_W:OUT_W-1]);
            nar_ovf = ~fits;
            nar_res = diff[OUT_W-1:0];
            if ((SAT != 0) && !fits) begin
               nar_res = diff[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end
         end
      end
   endgenerate

   logic [OUT_W-1:0] res_q [LAT-1];
   logic             ovf_q [LAT-1];
   logic [LAT-2:0]   vld_q;

   always_ff @(posedge clk) begin
      if (bus.ce) begin
         res_q[0] <= nar_res;
         ovf_q[0] <= nar_ovf;
         for (int i = 1; i < LAT - 1; i++) begin
            res_q[i] <= res_q[i-1];
            ovf_q[i] <= ovf_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else if (bus.ce) begin
         vld_q[0] <= bus.inValid;
         for (int i = 1; i < LAT - 1; i++) begin
            vld_q[i] <= vld_q[i-1];
         end
      end
   end

   // Result registers only load for a real result so they keep the last answer across bubbles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.outValid <= 1'b0;
         bus.subOut   <= '0;
         bus.ovf      <= 1'b0;
      end else if (bus.ce) begin
         bus.outValid <= vld_q[LAT-2];
         if (vld_q[LAT-2]) begin
            bus.subOut <= res_q[LAT-2];
            bus.ovf    <= ovf_q[LAT-2];
         end
      end
   end
endmodule

// File: tb/tb_signed_sub_pipe.sv
// Self-checking bench for signed_sub_pipe: eight parameter variants share one operand stream,
// with hand-computed directed checks plus a latency-stamped scoreboard against a reference model.
module tb_signed_sub_pipe;
   localparam int NDUT = 8;

   logic       clk;
   logic       rst_n;
   logic       ce;
   logic       in_valid;
   logic       is_signed;
   logic [3:0] a_in;
   logic [3:0] b_in;

   logic [7:0] o_res [NDUT];
   logic       o_v   [NDUT];
   logic       o_ovf [NDUT];

   int checks = 0;
   int errors = 0;

   function automatic int cfgOw(input int i);
      case (i)
         0: return 5;
         1: return 4;
         2: return 4;
         3: return 5;
         4: return 5;
         5: return 3;
         6: return 3;
         default: return 8;
      endcase
   endfunction

   function automatic int cfgSat(input int i);
      return (i == 2 || i == 6) ? 1 : 0;
   endfunction

   function automatic int cfgLat(input int i);
      case (i)
         3: return 2;
         4: return 16;
         5: return 3;
         6: return 5;
         default: return 4;
      endcase
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < NDUT; g++) begin : g_dut
         localparam int OW = cfgOw(g);
         signed_sub_pipe_if #(.IN_W(4), .OUT_W(OW)) bus ();
         signed_sub_pipe #(.IN_W(4), .OUT_W(OW), .LAT(cfgLat(g)), .SAT(cfgSat(g))) dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus)
         );
         assign bus.ce       = ce;
         assign bus.inValid  = in_valid;
         assign bus.isSigned = is_signed;
         assign bus.aIn      = a_in;
         assign bus.bIn      = b_in;
         assign o_res[g]     = 8'(bus.subOut);
         assign o_v[g]       = bus.outValid;
         assign o_ovf[g]     = bus.ovf;
      end
   endgenerate

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic c, input logic v, input logic sg,
                                input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      ce        = c;
      in_valid  = v;
      is_signed = sg;
      a_in      = a;
      b_in      = b;
   endtask

   // Reference narrowing: returns {ovf, result masked to ow bits}.
   function automatic logic [8:0] refModel(input logic [3:0] a, input logic [3:0] b,
                                           input logic sg, input int ow, input int sat);
      int ea, eb, d, lo, hi, r;
      logic o;
      ea = int'(a);
      eb = int'(b);
      if (sg && a[3]) ea -= 16;
      if (sg && b[3]) eb -= 16;
      d  = ea - eb;
      lo = -(1 << (ow - 1));
      hi = (1 << (ow - 1)) - 1;
      o  = 1'b0;
      r  = d;
      if (ow < 5 && (d < lo || d > hi)) begin
         o = 1'b1;
         if (sat != 0) r = (d > hi) ? hi : lo;
      end
      return {o, 8'(r & ((1 << ow) - 1))};
   endfunction

   logic [31:0] fifo [NDUT][64];
   int          wp [NDUT];
   int          rp [NDUT];
   int          en_cnt = 0;
   logic        sb_on  = 1'b0;
   logic [7:0]  p_res [NDUT];
   logic        p_v   [NDUT];
   logic        p_ovf [NDUT];
   logic        s_rst, s_ce, s_v, s_sg, exp_v;
   logic [3:0]  s_a, s_b;
   logic [31:0] head;

   initial begin
      for (int i = 0; i < NDUT; i++) begin
         wp[i] = 0;
         rp[i] = 0;
      end
   end

   // Scoreboard: every accepted op is stamped with the enabled-edge count and must emerge
   // exactly LAT-1 enabled edges later; ce=0 edges must hold outputs, reset edges must clear them.
   always @(posedge clk) begin
      s_rst = rst_n;
      s_ce  = ce;
      s_v   = in_valid;
      s_sg  = is_signed;
      s_a   = a_in;
      s_b   = b_in;
      #1;
      if (sb_on) begin
         if (!s_rst) begin
            for (int i = 0; i < NDUT; i++) begin
               checkOutput($sformatf("d%0d_rst_valid", i), 32'(o_v[i]), 0);
               checkOutput($sformatf("d%0d_rst_res", i), 32'(o_res[i]), 0);
               checkOutput($sformatf("d%0d_rst_ovf", i), 32'(o_ovf[i]), 0);
               rp[i] = wp[i];
            end
         end else if (!s_ce) begin
            for (int i = 0; i < NDUT; i++) begin
               checkOutput($sformatf("d%0d_hold_valid", i), 32'(o_v[i]), 32'(p_v[i]));
               checkOutput($sformatf("d%0d_hold_res", i), 32'(o_res[i]), 32'(p_res[i]));
               checkOutput($sformatf("d%0d_hold_ovf", i), 32'(o_ovf[i]), 32'(p_ovf[i]));
            end
         end else begin
            en_cnt++;
            for (int i = 0; i < NDUT; i++) begin
               if (s_v) begin
                  fifo[i][wp[i] % 64] = {16'(en_cnt), 7'b0, refModel(s_a, s_b, s_sg, cfgOw(i), cfgSat(i))};
                  wp[i]++;
               end
               head  = fifo[i][rp[i] % 64];
               exp_v = (rp[i] != wp[i]) && (int'(head[31:16]) + cfgLat(i) - 1 == en_cnt);
               checkOutput($sformatf("d%0d_valid@%0d", i, en_cnt), 32'(o_v[i]), 32'(exp_v));
               if (exp_v) begin
                  if (o_v[i]) begin
                     checkOutput($sformatf("d%0d_res@%0d", i, en_cnt), 32'(o_res[i]), 32'(head[7:0]));
                     checkOutput($sformatf("d%0d_ovf@%0d", i, en_cnt), 32'(o_ovf[i]), 32'(head[8]));
                  end
                  rp[i]++;
               end
            end
         end
      end
      for (int i = 0; i < NDUT; i++) begin
         p_res[i] = o_res[i];
         p_v[i]   = o_v[i];
         p_ovf[i] = o_ovf[i];
      end
   end

   logic c_rand;

   initial begin
      rst_n     = 1'b0;
      ce        = 1'b0;
      in_valid  = 1'b0;
      is_signed = 1'b0;
      a_in      = '0;
      b_in      = '0;
      @(negedge clk);
      sb_on = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Directed: 15-0, 0-15 unsigned, then signed -8-7.
      applyStimulus(1, 1, 0, 4'd15, 4'd0);
      applyStimulus(1, 1, 0, 4'd0, 4'd15);
      applyStimulus(1, 1, 1, 4'd8, 4'd7);
      applyStimulus(1, 0, 0, 4'd0, 4'd0);
      checkOutput("def_not_yet_valid", 32'(o_v[0]), 0);
      applyStimulus(1, 0, 0, 4'd0, 4'd0);
      checkOutput("def_op1_valid", 32'(o_v[0]), 1);
      checkOutput("def_op1_res", 32'(o_res[0]), 15);
      checkOutput("def_op1_ovf", 32'(o_ovf[0]), 0);
      checkOutput("wrap_op1_res", 32'(o_res[1]), 15);
      checkOutput("wrap_op1_ovf", 32'(o_ovf[1]), 1);
      checkOutput("sat_op1_res", 32'(o_res[2]), 7);
      checkOutput("sat_op1_ovf", 32'(o_ovf[2]), 1);
      checkOutput("w8_op1_res", 32'(o_res[7]), 15);
      applyStimulus(1, 0, 0, 4'd0, 4'd0);
      checkOutput("def_op2_valid", 32'(o_v[0]), 1);
      checkOutput("def_op2_res", 32'(o_res[0]), 17);
      checkOutput("def_op2_ovf", 32'(o_ovf[0]), 0);
      checkOutput("wrap_op2_res", 32'(o_res[1]), 1);
      checkOutput("wrap_op2_ovf", 32'(o_ovf[1]), 1);
      checkOutput("sat_op2_res", 32'(o_res[2]), 8);
      checkOutput("sat_op2_ovf", 32'(o_ovf[2]), 1);
      checkOutput("w8_op2_res", 32'(o_res[7]), 241);
      applyStimulus(1, 0, 0, 4'd0, 4'd0);
      checkOutput("def_op3_res", 32'(o_res[0]), 17);
      checkOutput("wrap_op3_res", 32'(o_res[1]), 1);
      checkOutput("sat_op3_res", 32'(o_res[2]), 8);
      checkOutput("sat_op3_ovf", 32'(o_ovf[2]), 1);
      applyStimulus(1, 0, 0, 4'd0, 4'd0);
      checkOutput("def_pulse_end", 32'(o_v[0]), 0);
      checkOutput("def_res_held", 32'(o_res[0]), 17);
      repeat (16) applyStimulus(1, 0, 0, 4'd0, 4'd0);

      // Stream with a three-cycle stall and two bubbles.
      for (int k = 0; k < 13; k++) begin
         applyStimulus(!(k >= 5 && k <= 7), !(k == 2 || k == 9), k[0],
                       4'((k * 3 + 1) % 16), 4'((k * 7 + 5) % 16));
      end
      repeat (18) applyStimulus(1, 0, 0, 4'd0, 4'd0);

      // Reset with three ops in flight, ce low during reset, then one fresh op.
      applyStimulus(1, 1, 0, 4'd9, 4'd2);
      applyStimulus(1, 1, 1, 4'd3, 4'd12);
      applyStimulus(1, 1, 0, 4'd1, 4'd14);
      @(negedge clk);
      rst_n    = 1'b0;
      ce       = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("post_rst_valid", 32'(o_v[0]), 0);
      checkOutput("post_rst_res", 32'(o_res[0]), 0);
      ce        = 1'b1;
      in_valid  = 1'b1;
      is_signed = 1'b0;
      a_in      = 4'd5;
      b_in      = 4'd3;
      repeat (4) applyStimulus(1, 0, 0, 4'd0, 4'd0);
      checkOutput("post_rst_op_valid", 32'(o_v[0]), 1);
      checkOutput("post_rst_op_res", 32'(o_res[0]), 2);
      repeat (16) applyStimulus(1, 0, 0, 4'd0, 4'd0);

      // Exhaustive operand sweep with random stalls and bubbles.
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               do begin
                  c_rand = ($urandom_range(0, 5) != 0);
                  applyStimulus(c_rand, 1, s[0], a[3:0], b[3:0]);
               end while (!c_rand);
               if ($urandom_range(0, 7) == 0) applyStimulus(1, 0, 0, 4'd0, 4'd0);
            end
         end
      end
      repeat (20) applyStimulus(1, 0, 0, 4'd0, 4'd0);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         checkOutput($sformatf("d%0d_pending", i), 32'(wp[i] - rp[i]), 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/signed_sub_pipe.md
SIGNED_SUB_PIPE -- requirements
Module: signed_sub_pipe

Interface
REQ-001 Parameter IN_W, default 4, operand width in bits; legal range 2..32.
REQ-002 Parameter OUT_W, default IN_W+1, result width in bits; legal range 2..IN_W+8.
REQ-003 Parameter LAT, default 4, input-to-output latency in enabled cycles; legal range 2..16.
REQ-004 Parameter SAT, default 0, narrowing mode: 0 = wrap (truncate), 1 = saturate.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 ce  in  1  pipeline enable; 0 freezes every stage.
REQ-008 inValid  in  1  aIn/bIn/isSigned carry an operation this cycle.
REQ-009 isSigned  in  1  1 = operands are two's complement; 0 = operands are unsigned.
REQ-010 aIn  in  IN_W  minuend.
REQ-011 bIn  in  IN_W  subtrahend.
REQ-012 subOut  out  OUT_W  signed result a-b, registered.
REQ-013 outValid  out  1  subOut/ovf hold a new result this cycle, registered.
REQ-014 ovf  out  1  result of this operation was not representable in OUT_W bits, registered.

Function
REQ-015 Operands SHALL be extended to IN_W+1 bits: sign-extended if isSigned=1, zero-extended if isSigned=0; isSigned is sampled with its operands and travels with them.
REQ-016 Exact difference D = ext(a) - ext(b) SHALL be formed in IN_W+1 signed bits; D is always exact.
REQ-017 If OUT_W >= IN_W+1, subOut SHALL be D sign-extended to OUT_W bits and ovf SHALL be 0.
REQ-018 If OUT_W < IN_W+1 and SAT=0, subOut SHALL be D[OUT_W-1:0]; ovf SHALL be 1 iff D lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-019 If OUT_W < IN_W+1 and SAT=1, subOut SHALL be D clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; ovf SHALL be 1 iff clamping occurred.
REQ-020 An operation sampled on an edge with ce=1 and inValid=1 SHALL appear on subOut with outValid=1 after exactly LAT edges that have ce=1.
REQ-021 A valid bit SHALL travel with each stage; bubbles (inValid=0) SHALL propagate as outValid=0.
REQ-022 On an edge with ce=0, all stages and outputs SHALL hold, and inputs SHALL be ignored.
REQ-023 subOut and ovf SHALL load only when the final-stage valid is 1 and ce=1; otherwise they SHALL hold their last value.
REQ-024 outValid SHALL be a one-cycle-per-result pulse; it SHALL be held unchanged during a ce=0 cycle.
REQ-025 Back-to-back operations at one per enabled cycle SHALL be supported with no throughput loss.
REQ-026 Extension, subtraction and narrowing SHALL complete within the LAT stages; the remaining stages are pure delay.

Reset
REQ-027 On an edge with rst_n=0, all valid bits, outValid, subOut and ovf SHALL become 0, regardless of ce.
REQ-028 Operations in flight at reset SHALL be discarded; no outValid SHALL appear for them after reset release.
REQ-029 Internal data stages other than the outputs and valid bits need not be reset.
REQ-030 The first operation accepted after rst_n returns to 1 SHALL emerge after LAT enabled edges.

Verification
REQ-031 Defaults (IN_W=4, OUT_W=5), isSigned=0, a=15, b=0 -> after 4 cycles: subOut=15, ovf=0. Next op a=0, b=15 -> subOut=-15, ovf=0.
REQ-032 IN_W=4, OUT_W=4, SAT=0, unsigned a=15, b=0 -> subOut=4'b1111 (-1), ovf=1. a=0, b=15 -> subOut=1, ovf=1.
REQ-033 IN_W=4, OUT_W=4, SAT=1, same stimulus as REQ-032 -> subOut=7, ovf=1, then subOut=-8, ovf=1. Signed a=-8, b=7 -> subOut=-8, ovf=1.
REQ-034 Stream 8 ops; hold ce=0 for 3 cycles mid-stream; insert 2 bubbles -> results arrive in order, unchanged, with outValid pattern matching the input pattern delayed by LAT enabled edges.
REQ-035 Issue 3 ops, assert rst_n=0 for 1 cycle while they are in flight -> outputs are 0 the next cycle and no outValid appears for those 3 ops. A new op issued after reset emerges after LAT.
REQ-036 Repeat REQ-031 with LAT=2 and LAT=16; random sweep over all a, b, isSigned for IN_W=4 against a reference model for each OUT_W/SAT combination.
